histogram_reader: RTL and testbench



---
 rtl/hist_pkg.sv | 19 +
 rtl/histogram_reader.sv | 123 ++++++++++++
 tb/tb_histogram_reader.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/hist_pkg.sv
// rtl/hist_pkg.sv - shared sizes and readout state type for the histogram reader
package hist_pkg;

  localparam int BINS   = 256;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 18;
  localparam int CUM_W  = 26;
  localparam int RD_LAT = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_EMIT,
    S_CLEAR,
    S_DONE
  } hist_rd_state_t;

endpackage

// File: rtl/histogram_reader.sv
// rtl/histogram_reader.sv - sweeps the histogram store, streams bins with cumulative counts, finds the percentile bin
module histogram_reader #(
  parameter int BINS   = hist_pkg::BINS,
  parameter int ADDR_W = hist_pkg::ADDR_W,
  parameter int CNT_W  = hist_pkg::CNT_W,
  parameter int CUM_W  = hist_pkg::CUM_W,
  parameter int RD_LAT = hist_pkg::RD_LAT
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iStart,
  input  logic [CUM_W-1:0]  iTarget,
  output logic              oRdEn,
  output logic [ADDR_W-1:0] oRdAddr,
  input  logic [CNT_W-1:0]  iRdData,
  output logic              oValid,
  input  logic              iReady,
  output logic [ADDR_W-1:0] oBin,
  output logic [CNT_W-1:0]  oCount,
  output logic [CUM_W-1:0]  oCum,
  output logic              oLast,
  output logic              oClearRam,
  output logic [ADDR_W-1:0] oThresh,
  output logic              oThreshFound,
  output logic              oBusy,
  output logic              oDone
);
  import hist_pkg::*;

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BINS - 1);

  hist_rd_state_t state, stateNext;

  logic [ADDR_W-1:0] addr;
  logic [LAT_W-1:0]  latCnt;
  logic [CUM_W-1:0]  target;
  logic [CUM_W-1:0]  cum;
  logic [CUM_W-1:0]  cumNext;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] thresh;
  logic              found;
  logic              isLast;
  logic              xfer;

  assign isLast  = (addr == LAST_ADDR);
  assign xfer    = (state == S_EMIT) && iReady;
  assign cumNext = cum + CUM_W'(iRdData);

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state  <= S_IDLE;
      addr   <= '0;
      latCnt <= '0;
      target <= '0;
      cum    <= '0;
      count  <= '0;
      thresh <= '0;
      found  <= 1'b0;
    end else begin
      state <= stateNext;
      case (state)
        S_IDLE: begin
          if (iStart) begin
            target <= iTarget;
            cum    <= '0;
            addr   <= '0;
            thresh <= '0;
            found  <= 1'b0;
          end
        end
        S_READ: latCnt <= LAT_W'(RD_LAT - 1);
        S_WAIT: begin
          if (latCnt == '0) begin
            count <= iRdData;
            cum   <= cumNext;
            // First bin whose cumulative count reaches the target wins; later bins never override it
            if (!found && (cumNext >= target)) begin
              found  <= 1'b1;
              thresh <= addr;
            end
          end else begin
            latCnt <= latCnt - 1'b1;
          end
        end
        S_EMIT: begin
          if (xfer) begin
            if (!isLast) addr <= addr + 1'b1;
            else if (!found) thresh <= LAST_ADDR;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      S_IDLE:  if (iStart) stateNext = S_READ;
      S_READ:  stateNext = S_WAIT;
      S_WAIT:  if (latCnt == '0) stateNext = S_EMIT;
      S_EMIT:  if (xfer) stateNext = isLast ? S_CLEAR : S_READ;
      S_CLEAR: stateNext = S_DONE;
      S_DONE:  stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  assign oRdEn        = (state == S_READ);
  assign oRdAddr      = addr;
  assign oValid       = (state == S_EMIT);
  assign oBin         = addr;
  assign oCount       = count;
  assign oCum         = cum;
  assign oLast        = (state == S_EMIT) && isLast;
  assign oClearRam    = (state == S_CLEAR);
  assign oThresh      = thresh;
  assign oThreshFound = found;
  assign oBusy        = (state != S_IDLE);
  assign oDone        = (state == S_DONE);

endmodule

// File: tb/tb_histogram_reader.sv
// tb/tb_histogram_reader.sv - directed bench with a fixed-latency store model and a cumulative-histogram reference
module tb_histogram_reader;
  import hist_pkg::*;

  logic              iClk = 1'b0;
  logic              iRst_n = 1'b0;
  logic              iStart = 1'b0;
  logic [CUM_W-1:0]  iTarget = '0;
  logic              oRdEn;
  logic [ADDR_W-1:0] oRdAddr;
  logic [CNT_W-1:0]  iRdData;
  logic              oValid;
  logic              iReady = 1'b1;
  logic [ADDR_W-1:0] oBin;
  logic [CNT_W-1:0]  oCount;
  logic [CUM_W-1:0]  oCum;
  logic              oLast;
  logic              oClearRam;
  logic [ADDR_W-1:0] oThresh;
  logic              oThreshFound;
  logic              oBusy;
  logic              oDone;

  histogram_reader dut (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iTarget(iTarget),
    .oRdEn(oRdEn), .oRdAddr(oRdAddr), .iRdData(iRdData),
    .oValid(oValid), .iReady(iReady), .oBin(oBin), .oCount(oCount),
    .oCum(oCum), .oLast(oLast), .oClearRam(oClearRam), .oThresh(oThresh),
    .oThreshFound(oThreshFound), .oBusy(oBusy), .oDone(oDone)
  );

  always #5 iClk = ~iClk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Store model: data for an address strobed in cycle t appears during cycle t+RD_LAT, garbage otherwise
  logic [CNT_W-1:0]  mem [BINS];
  logic [RD_LAT-1:0] pipeV = '0;
  logic [ADDR_W-1:0] pipeA [RD_LAT];
  always @(posedge iClk) begin
    for (int i = RD_LAT - 1; i > 0; i--) begin
      pipeV[i] <= pipeV[i-1];
      pipeA[i] <= pipeA[i-1];
    end
    pipeV[0] <= oRdEn;
    pipeA[0] <= oRdAddr;
  end
  assign iRdData = pipeV[RD_LAT-1] ? mem[pipeA[RD_LAT-1]] : 18'h2A5A5;

  // Reference results computed from the histogram contents
  logic [CUM_W-1:0] expCum [BINS];
  int  expThr;
  bit  expFound;
  bit  checkEn = 0;
  bit  randReady = 0;
  int  beatIdx = 0;
  int  clearCnt = 0;
  int  doneCnt = 0;
  int  clearCyc = 0;
  int  doneCyc = 0;

  initial forever begin
    @(posedge iClk);
    #1;
    iReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge iClk) begin
    if (oClearRam) begin clearCnt++; clearCyc = cyc; end
    if (oDone) begin doneCnt++; doneCyc = cyc; end
    if (checkEn && oValid) begin
      if (beatIdx >= BINS) begin
        chk("extraBeat", 64'(beatIdx), 64'(BINS - 1));
      end else begin
        chk("beatBin", oBin, 64'(beatIdx));
        chk("beatCount", oCount, mem[beatIdx]);
        chk("beatCum", oCum, expCum[beatIdx]);
        chk("beatLast", oLast, 64'(beatIdx == BINS - 1));
        chk("beatFound", oThreshFound, 64'(expFound && beatIdx >= expThr));
        if (oThreshFound) chk("beatThresh", oThresh, 64'(expThr));
        if (iReady) beatIdx++;
      end
    end
  end

  task automatic buildModel(input logic [CUM_W-1:0] target);
    logic [CUM_W-1:0] c;
    c = '0;
    expFound = 0;
    expThr = BINS - 1;
    for (int b = 0; b < BINS; b++) begin
      c = c + CUM_W'(mem[b]);
      expCum[b] = c;
      if (!expFound && c >= target) begin expFound = 1; expThr = b; end
    end
  endtask

  task automatic runSweep(input logic [CUM_W-1:0] target, input bit rr, input bit midStart,
                          input int stopBin, output int lat);
    int acceptCyc;
    buildModel(target);
    randReady = rr;
    beatIdx = 0; clearCnt = 0; doneCnt = 0;
    lat = -1;
    @(posedge iClk); #1;
    checkEn = 1;
    iTarget = target;
    iStart = 1;
    @(posedge iClk); #1;
    iStart = 0;
    acceptCyc = cyc - 1;
    for (int n = 0; n < 20000 && doneCnt == 0; n++) begin
      @(negedge iClk);
      if (midStart && n == 50) iStart = 1;
      if (midStart && n == 51) iStart = 0;
      if (stopBin >= 0 && oValid && oBin == ADDR_W'(stopBin)) begin
        checkEn = 0;
        iRst_n = 0;
        @(negedge iClk);
        chk("midResetOutputs",
            64'({oRdEn, oRdAddr, oValid, oBin, oCount, oCum, oLast, oClearRam,
                 oThresh, oThreshFound, oBusy, oDone}), 64'd0);
        @(posedge iClk); #1;
        iRst_n = 1;
        repeat (5) @(negedge iClk);
        chk("midResetNoClear", 64'(clearCnt), 64'd0);
        chk("midResetNoDone", 64'(doneCnt), 64'd0);
        chk("midResetIdle", oBusy, 64'd0);
        return;
      end
    end
    checkEn = 0;
    if (doneCnt == 0) begin
      chk("doneTimeout", 64'd0, 64'd1);
      return;
    end
    lat = doneCyc - acceptCyc;
    chk("clearBeforeDone", 64'(doneCyc - clearCyc), 64'd1);
    repeat (10) @(negedge iClk);
    chk("beatsSeen", 64'(beatIdx), 64'(BINS));
    chk("clearCount", 64'(clearCnt), 64'd1);
    chk("doneCount", 64'(doneCnt), 64'd1);
    chk("threshBin", oThresh, 64'(expThr));
    chk("threshFound", oThreshFound, 64'(expFound));
    chk("busyAfter", oBusy, 64'd0);
  endtask

  initial begin
    int lat;
    for (int b = 0; b < BINS; b++) mem[b] = 18'd1000;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    chk("resetOutputs",
        64'({oRdEn, oRdAddr, oValid, oBin, oCount, oCum, oLast, oClearRam,
             oThresh, oThreshFound, oBusy, oDone}), 64'd0);
    @(posedge iClk); #1;
    iRst_n = 1;

    // Uniform histogram
    runSweep(26'd128000, 0, 0, -1, lat);
    chk("uniModelCum127", expCum[127], 64'd128000);
    chk("uniLatency", 64'(lat), 64'd1026);
    chk("uniThresh", oThresh, 64'd127);
    chk("uniFound", oThreshFound, 64'd1);

    // Single peak
    for (int b = 0; b < BINS; b++) mem[b] = (b == 200) ? 18'd50000 : 18'd0;
    runSweep(26'd1, 0, 0, -1, lat);
    chk("peakModelCumLast", expCum[255], 64'd50000);
    chk("peakThresh", oThresh, 64'd200);

    // Saturated bins, unreachable target
    for (int b = 0; b < BINS; b++) mem[b] = 18'h3FFFF;
    runSweep(26'h3FFFFFF, 0, 0, -1, lat);
    chk("maxModelCumLast", expCum[255], 64'd67108608);
    chk("maxThresh", oThresh, 64'd255);
    chk("maxFound", oThreshFound, 64'd0);

    // Varied data with random backpressure
    for (int b = 0; b < BINS; b++) mem[b] = 18'((b * 37 + 5) % 1000);
    runSweep(26'd60000, 1, 0, -1, lat);

    // Zero target, start pulsed mid-sweep
    for (int b = 0; b < BINS; b++) mem[b] = 18'd1000;
    runSweep(26'd0, 0, 1, -1, lat);
    chk("zeroThresh", oThresh, 64'd0);
    chk("zeroLatency", 64'(lat), 64'd1026);

    // Reset in EMIT of bin 100, then a clean restart from bin 0
    runSweep(26'd128000, 0, 0, 100, lat);
    runSweep(26'd128000, 1, 0, -1, lat);
    chk("restartThresh", oThresh, 64'd127);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
